bcd_to_binary: RTL and testbench

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary_if.sv | 23 ++
 rtl/bcd_to_binary.sv | 122 ++++++++++++
 tb/tb_bcd_to_binary.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the 3-digit BCD to binary converter.
// The master drives the start strobe and BCD digits; the slave returns status and result.
interface bcd_to_binary_if;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [9:0] binary;
    logic       ovf8;
    logic       err;

    modport master (
        output start, hundreds, tens, ones,
        input  busy, done, binary, ovf8, err
    );

    modport slave (
        input  start, hundreds, tens, ones,
        output busy, done, binary, ovf8, err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to 10-bit binary converter using reverse double-dabble.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 (err) instead of converting them.
module bcd_to_binary (
    input  logic             clk,
    input  logic             rst_n,
    bcd_to_binary_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state_q;
    logic [11:0] bcd_q;
    logic [9:0]  result_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [9:0]  binary_q;
    logic        ovf8_q;

    logic [11:0] bcd_d;
    logic [9:0]  result_d;
    logic [11:0] bcd_shifted;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic        bad_q;
    logic        err_q;
    logic        digit_bad;
`endif

    // Undo the x2 weighting a BCD nibble picks up when it receives a bit from its upper neighbour.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    always_comb begin
        bcd_shifted = {1'b0, bcd_q[11:1]};
        result_d    = {bcd_q[0], result_q[9:1]};
        bcd_d       = {dabble(bcd_shifted[11:8]),
                       dabble(bcd_shifted[7:4]),
                       dabble(bcd_shifted[3:0])};
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign digit_bad = (bus.hundreds > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);
`endif

    // Outputs are registered from the current state, so done and the result
    // appear in the cycle after the FSM sits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            binary_q <= '0;
            ovf8_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= bus.start;
                    if (bus.start) begin
                        bcd_q    <= {bus.hundreds, bus.tens, bus.ones};
                        result_q <= '0;
                        cnt_q    <= 4'd9;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        bad_q    <= digit_bad;
                        state_q  <= digit_bad ? DONE : CONV;
`else
                        state_q  <= CONV;
`endif
                    end
                end
                CONV: begin
                    bcd_q    <= bcd_d;
                    result_q <= result_d;
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    if (bad_q) begin
                        binary_q <= '0;
                        ovf8_q   <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        binary_q <= result_q;
                        ovf8_q   <= (result_q > 10'd255);
                        err_q    <= 1'b0;
                    end
`else
                    binary_q <= result_q;
                    ovf8_q   <= (result_q > 10'd255);
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.binary = binary_q;
    assign bus.ovf8   = ovf8_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: table of digit triples plus hand-written
// sequences for ignored start, mid-conversion reset, back-to-back and digit check.
module tb_bcd_to_binary;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bcd_to_binary_if bus();

    bcd_to_binary dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        int         exp_bin;
        int         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present digits with start for exactly one rising edge, then scramble the digits.
    task automatic launch(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.hundreds = h;
        bus.tens     = t;
        bus.ones     = o;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.hundreds = 4'($urandom_range(0, 15));
        bus.tens     = 4'($urandom_range(0, 15));
        bus.ones     = 4'($urandom_range(0, 15));
    endtask

    // j counts cycles after the start edge; lat=-1 if done never shows.
    task automatic wait_done(input int limit, output int lat, output int busy_low);
        lat      = -1;
        busy_low = 0;
        for (int j = 0; j < limit; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
            if (!bus.busy) busy_low++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input int exp_bin, input int exp_ovf);
        int lat;
        int bl;
        int held;
        launch(h, t, o);
        wait_done(30, lat, bl);
        chk({tag, " latency"}, lat, 11);
        chk({tag, " busy_low"}, bl, 0);
        chk({tag, " binary"}, int'(bus.binary), exp_bin);
        chk({tag, " ovf8"}, int'(bus.ovf8), exp_ovf);
        chk({tag, " err"}, int'(bus.err), 0);
        held = int'(bus.binary);
        @(negedge clk);
        chk({tag, " done_drop"}, int'(bus.done), 0);
        chk({tag, " binary_hold"}, int'(bus.binary), held);
        chk({tag, " hold_value"}, held, exp_bin);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   bl;
        int   ndone;
        int   first;
        int   val;
        int   prev;
        int   gap_bad;
        int   val_bad;

        total = 0;
        bad   = 0;

        vecs[0] = '{4'd2, 4'd5, 4'd5, 255, 0};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 999, 1};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 0,   0};
        vecs[3] = '{4'd2, 4'd5, 4'd6, 256, 1};
        vecs[4] = '{4'd1, 4'd2, 4'd3, 123, 0};
        vecs[5] = '{4'd0, 4'd4, 4'd2, 42,  0};
        vecs[6] = '{4'd5, 4'd0, 4'd9, 509, 1};
        vecs[7] = '{4'd0, 4'd9, 4'd9, 99,  0};

        bus.start    = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        rst_n        = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset busy",   int'(bus.busy),   0);
        chk("reset done",   int'(bus.done),   0);
        chk("reset binary", int'(bus.binary), 0);
        chk("reset ovf8",   int'(bus.ovf8),   0);
        chk("reset err",    int'(bus.err),    0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].o,
                     vecs[i].exp_bin, vecs[i].exp_ovf);
        end

        // start during CONV must not restart or queue a conversion
        launch(4'd2, 4'd5, 4'd5);
        ndone = 0;
        first = -1;
        val   = -1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first < 0) begin
                    first = j;
                    val   = int'(bus.binary);
                end
            end
            if (j == 3) begin
                bus.start    = 1'b1;
                bus.hundreds = 4'd1;
                bus.tens     = 4'd2;
                bus.ones     = 4'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("ignore done_count", ndone, 1);
        chk("ignore latency", first, 11);
        chk("ignore binary", val, 255);

        // asynchronous reset in the middle of a conversion
        launch(4'd9, 4'd9, 4'd9);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy",   int'(bus.busy),   0);
        chk("midrst done",   int'(bus.done),   0);
        chk("midrst binary", int'(bus.binary), 0);
        chk("midrst ovf8",   int'(bus.ovf8),   0);
        chk("midrst err",    int'(bus.err),    0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        run_conv("after_rst", 4'd1, 4'd2, 4'd3, 123, 0);

        // start held high: a new conversion every 12 cycles
        @(negedge clk);
        bus.start    = 1'b1;
        bus.hundreds = 4'd1;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        ndone   = 0;
        prev    = -1;
        first   = -1;
        gap_bad = 0;
        val_bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first < 0) first = c;
                if (prev >= 0 && (c - prev) != 12) gap_bad++;
                if (bus.binary != 10'd100) val_bad++;
                prev = c;
            end
        end
        bus.start = 1'b0;
        chk("b2b done_count", ndone, 4);
        chk("b2b first", first, 11);
        chk("b2b gap_errors", gap_bad, 0);
        chk("b2b value_errors", val_bad, 0);
        wait_done(30, lat, bl);
        chk("b2b drain", (lat >= 0) ? 1 : 0, 1);
        @(negedge clk);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        launch(4'd0, 4'd10, 4'd0);
        wait_done(30, lat, bl);
        chk("digit latency", lat, 1);
        chk("digit err", int'(bus.err), 1);
        chk("digit binary", int'(bus.binary), 0);
        chk("digit ovf8", int'(bus.ovf8), 0);
        @(negedge clk);
        run_conv("digit_ok", 4'd0, 4'd4, 4'd2, 42, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
